branch_redirect: RTL and testbench
==================================

# branch_redirect

Branch resolution and fetch-redirect controller sitting directly downstream of the execute-stage condition unit. It consumes the resolved `takeBranchE` decision and the branch target, then drives the fetch PC redirect and squashes the wrong-path instructions in decode and execute. A stall in fetch holds the redirect until fetch accepts it. The block also keeps saturating branch and taken-branch counters for performance monitoring. The pipeline fetches not-taken by default, so every taken branch is a redirect.

## Interface
- `ADDRWIDTH`, default 32: PC / branch target width.
- `CNTWIDTH`, default 16: width of each statistics counter.

- `clk`  in  1  pipeline clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `validE`  in  1  execute stage holds a valid (non-bubble) instruction.
- `isBranchE`  in  1  execute instruction is a branch opcode.
- `takeBranchE`  in  1  condition unit decision for the execute instruction.
- `branchTargetE`  in  ADDRWIDTH  computed branch target.
- `stallF`  in  1  fetch cannot accept a new PC this cycle.
- `clearStats`  in  1  synchronous clear of both counters.
- `pcRedirectF`  out  1  fetch must load `pcTargetF`.
- `pcTargetF`  out  ADDRWIDTH  redirect target.
- `flushD`  out  1  squash the instruction currently in decode.
- `flushE`  out  1  squash the instruction currently in execute.
- `busy`  out  1  redirect in progress (state ≠ IDLE).
- `branchCount`  out  CNTWIDTH  resolved branches, saturating.
- `takenCount`  out  CNTWIDTH  taken branches, saturating.

## Operation
- Accept condition: `accept = validE & isBranchE & takeBranchE & (state == IDLE)`.
- FSM states and transitions:
  - IDLE: all control outputs are 0. On `accept`, latch `branchTargetE` into the target register and go to REDIRECT.
  - REDIRECT: `pcRedirectF`, `flushD`, `flushE` and `busy` are 1. If `stallF=1`, go to HOLD; otherwise go to IDLE.
  - HOLD: `pcRedirectF`, `flushD` and `busy` are 1; `flushE` is 0. Stay while `stallF=1`; go to IDLE on the first cycle with `stallF=0`. This cycle still asserts the redirect.
- While in REDIRECT or HOLD:
  - `takeBranchE`, `isBranchE` and `validE` are ignored, because execute holds a wrong-path instruction or a bubble.
  - The counters do not increment.
  - The target register does not change.
- If `takeBranchE=1` with `validE=0` or `isBranchE=0`, the block ignores it with no redirect and no count.
- Counters:
  - `branchCount` increments on `validE & isBranchE` in IDLE.
  - `takenCount` increments on `accept`.
  - Both saturate at 2^CNTWIDTH−1 and never wrap.
- `clearStats` zeroes both counters on the next edge. If a clear and an increment happen in the same cycle, the clear wins and the counter reads 0.
- `pcTargetF` always shows the target register. Its value is only meaningful while `pcRedirectF=1`.

## Timing
- Branch resolved in E at cycle T gives `pcRedirectF`/`flushD`/`flushE` = 1 during cycle T+1, so latency is 1 cycle.
- All outputs are Moore outputs driven from registers, with no combinational path from inputs to outputs.
- When `stallF=0`, the redirect pulse is exactly 1 cycle. When `stallF=1` in cycle T+1, the redirect persists until the first cycle with `stallF=0`, that cycle included.
- A new branch can be accepted the first cycle the FSM is back in IDLE (earliest T+2).
- Counters update at the edge ending the accept cycle and are visible in T+1.
- Reset values: state IDLE, every output 0, target register 0, counters 0.
- Reset asserted during REDIRECT or HOLD forces IDLE immediately, with no redirect after release.

## Structure
- Shared package `branch_pkg`: state enum typedef `redirect_state_t` {IDLE, REDIRECT, HOLD}, plus default width constants.
- Sub-module `sat_counter` (parameter WIDTH; inputs `inc` and `clr`, with `clr` priority; output `count`), instantiated twice.
- FSM, target register and output decode live in the top module.

## Test plan
- Taken branch, no stall: `validE=isBranchE=takeBranchE=1`, `branchTargetE=0x0000_0040`, `stallF=0` at T.
  - T+1: `pcRedirectF=flushD=flushE=1`, `pcTargetF=0x40`.
  - T+2: all outputs 0.
  - Counters read 1/1.
- Redirect under stall: same stimulus with target 0x80, `stallF=1` for T+1..T+3.
  - T+1: REDIRECT with `flushE=1`.
  - T+2, T+3: HOLD with `flushE=0`, `pcRedirectF=1`.
  - T+4 (`stallF=0`): `pcRedirectF=1` (last redirect cycle).
  - T+5: IDLE.
- Not-taken and bubble filtering:
  - `isBranchE=1`, `takeBranchE=0` gives no redirect; `branchCount` rises by 1, `takenCount` unchanged.
  - `validE=0`, `takeBranchE=1` gives no redirect and no count change.
- Wrong-path masking: taken branch at T, then `takeBranchE=1` again at T+1 with target 0x99.
  - Only one redirect pulse; `pcTargetF` stays at the first target; `takenCount` rises by 1.
- Saturation and clear: preload via 2^16 taken branches.
  - `takenCount` holds at 0xFFFF on further branches.
  - `clearStats` concurrent with an accept gives 0 on the next cycle.
- Async reset during HOLD: drop `rst_n` mid-HOLD.
  - All outputs go to 0 without waiting for a clock.
  - After release with `stallF=0`, no redirect.

Source files
------------

// File: rtl/branch_pkg.sv
// branch_pkg: shared state encoding and default widths for the branch redirect controller
package branch_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        HOLD     = 2'd2
    } redirect_state_t;

    localparam int DEF_ADDRWIDTH = 32;
    localparam int DEF_CNTWIDTH  = 16;

endpackage

// File: rtl/branch_redirect_sat_counter.sv
// sat_counter: saturating up-counter with a synchronous clear that beats increment
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    // clear first, then increment unless already at the all-ones ceiling
    always_comb begin
        count_d = clr ? '0 : (inc && count_q != '1) ? count_q + WIDTH'(1) : count_q;
    end

    // counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/branch_redirect.sv
// branch_redirect: turns a taken execute-stage branch into a fetch redirect plus D/E squash
module branch_redirect
    import branch_pkg::*;
#(
    parameter int ADDRWIDTH = DEF_ADDRWIDTH,
    parameter int CNTWIDTH  = DEF_CNTWIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 validE,
    input  logic                 isBranchE,
    input  logic                 takeBranchE,
    input  logic [ADDRWIDTH-1:0] branchTargetE,
    input  logic                 stallF,
    input  logic                 clearStats,
    output logic                 pcRedirectF,
    output logic [ADDRWIDTH-1:0] pcTargetF,
    output logic                 flushD,
    output logic                 flushE,
    output logic                 busy,
    output logic [CNTWIDTH-1:0]  branchCount,
    output logic [CNTWIDTH-1:0]  takenCount
);

    redirect_state_t      state_q, state_d;
    logic [ADDRWIDTH-1:0] target_q, target_d;
    logic                 br_inc, accept;

    // execute is only trusted in IDLE; during a redirect it holds wrong-path work
    always_comb begin
        br_inc   = validE & isBranchE & (state_q == IDLE);
        accept   = br_inc & takeBranchE;
        state_d  = (state_q == IDLE) ? (accept ? REDIRECT : IDLE) : (stallF ? HOLD : IDLE);
        target_d = accept ? branchTargetE : target_q;
    end

    // state and target registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
        end
    end

    // execute is only squashed on the first redirect cycle; later HOLD cycles see a new E
    assign busy        = state_q != IDLE;
    assign pcRedirectF = busy;
    assign flushD      = busy;
    assign flushE      = state_q == REDIRECT;
    assign pcTargetF   = target_q;

    sat_counter #(.WIDTH(CNTWIDTH)) u_branch_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (br_inc),
        .clr   (clearStats),
        .count (branchCount)
    );

    sat_counter #(.WIDTH(CNTWIDTH)) u_taken_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (accept),
        .clr   (clearStats),
        .count (takenCount)
    );

endmodule

// File: tb/tb_branch_redirect.sv
// tb_branch_redirect: directed and random stimulus against a redirect-phase reference model
module tb_branch_redirect;

    localparam int AW   = 32;
    localparam int CW   = 8;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          validE = 1'b0, isBranchE = 1'b0, takeBranchE = 1'b0;
    logic [AW-1:0] branchTargetE = '0;
    logic          stallF = 1'b0, clearStats = 1'b0;
    logic          pcRedirectF, flushD, flushE, busy;
    logic [AW-1:0] pcTargetF;
    logic [CW-1:0] branchCount, takenCount;

    int total = 0;
    int bad = 0;

    bit            m_act, m_first;
    logic [AW-1:0] m_tgt;
    int            m_bc, m_tc;

    always #5 clk = ~clk;

    branch_redirect #(.ADDRWIDTH(AW), .CNTWIDTH(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .validE        (validE),
        .isBranchE     (isBranchE),
        .takeBranchE   (takeBranchE),
        .branchTargetE (branchTargetE),
        .stallF        (stallF),
        .clearStats    (clearStats),
        .pcRedirectF   (pcRedirectF),
        .pcTargetF     (pcTargetF),
        .flushD        (flushD),
        .flushE        (flushE),
        .busy          (busy),
        .branchCount   (branchCount),
        .takenCount    (takenCount)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_act = 0; m_first = 0; m_tgt = '0; m_bc = 0; m_tc = 0;
    endtask

    task automatic check_all();
        chk("pcRedirectF", 64'(pcRedirectF), 64'(m_act));
        chk("flushD", 64'(flushD), 64'(m_act));
        chk("flushE", 64'(flushE), 64'(m_act && m_first));
        chk("busy", 64'(busy), 64'(m_act));
        chk("pcTargetF", 64'(pcTargetF), 64'(m_tgt));
        chk("branchCount", 64'(branchCount), 64'(m_bc));
        chk("takenCount", 64'(takenCount), 64'(m_tc));
    endtask

    // one cycle: check what the DUT shows now, then present inputs for the next edge
    task automatic step(input logic v, input logic b, input logic t, input logic [AW-1:0] tg,
                        input logic s, input logic c);
        @(negedge clk);
        check_all();
        validE = v; isBranchE = b; takeBranchE = t; branchTargetE = tg; stallF = s; clearStats = c;
        if (rst_n) begin
            if (m_act) begin
                m_first = 0;
                if (!s) m_act = 0;
            end else if (v && b) begin
                if (m_bc < MAXC) m_bc++;
                if (t) begin
                    if (m_tc < MAXC) m_tc++;
                    m_tgt = tg; m_act = 1; m_first = 1;
                end
            end
            if (c) begin m_bc = 0; m_tc = 0; end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, '0, 0, 0);
    endtask

    initial begin
        model_reset();
        #1;
        chk("rst_redirect", 64'(pcRedirectF), 64'(0));
        chk("rst_flushE", 64'(flushE), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_target", 64'(pcTargetF), 64'(0));
        idle(2);
        rst_n = 1'b1;
        idle(1);
        // taken branch, no stall
        step(1, 1, 1, 32'h40, 0, 0);
        idle(3);
        // redirect under stall
        step(1, 1, 1, 32'h80, 0, 0);
        repeat (3) step(0, 0, 0, '0, 1, 0);
        idle(3);
        // not-taken and bubble filtering
        step(1, 1, 0, 32'h11, 0, 0);
        step(0, 1, 1, 32'h22, 0, 0);
        step(1, 0, 1, 32'h33, 0, 0);
        idle(2);
        // wrong-path masking
        step(1, 1, 1, 32'h40, 0, 0);
        step(1, 1, 1, 32'h99, 0, 0);
        idle(3);
        // saturation, then clear concurrent with accept
        repeat (MAXC + 5) begin
            step(1, 1, 1, $urandom, 0, 0);
            step(0, 0, 0, '0, 0, 0);
        end
        @(negedge clk);
        chk("sat_taken", 64'(takenCount), 64'(MAXC));
        step(1, 1, 1, 32'h10, 0, 1);
        idle(3);
        // async reset in HOLD
        step(1, 1, 1, 32'hC0, 0, 0);
        step(0, 0, 0, '0, 1, 0);
        step(0, 0, 0, '0, 1, 0);
        #2;
        chk("pre_rst_hold", 64'(pcRedirectF), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("async_redirect", 64'(pcRedirectF), 64'(0));
        chk("async_flushD", 64'(flushD), 64'(0));
        chk("async_busy", 64'(busy), 64'(0));
        chk("async_target", 64'(pcTargetF), 64'(0));
        chk("async_taken", 64'(takenCount), 64'(0));
        model_reset();
        idle(2);
        rst_n = 1'b1;
        idle(3);
        // random traffic
        repeat (4000)
            step(($urandom % 4) != 0, $urandom % 2, $urandom % 2, $urandom,
                 ($urandom % 3) == 0, ($urandom % 300) == 0);
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
